divider_multicycle: RTL and testbench

//  Iterative radix-2 restoring divider for the execute stage; serves RV64M DIV/DIVU/REM/REMU.

---
 rtl/divider_multicycle_pkg.sv | 18 +
 rtl/divider_multicycle_step.sv | 27 ++
 rtl/divider_multicycle.sv | 100 ++++++++++
 tb/tb_divider_multicycle.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/divider_multicycle_pkg.sv
// Shared types for the multicycle divider: scalar aliases, FSM states, counter sizing.
package divider_multicycle_pkg;

  typedef logic        u1;
  typedef logic [63:0] u64;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Iteration counter must hold the value WIDTH itself, hence the extra bit.
  function automatic int unsigned div_cnt_w(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/divider_multicycle_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, trial-subtract, restore on borrow.
module divider_step #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] quo_n
);

  logic [WIDTH:0] remq;
  logic [WIDTH:0] diff;

  always_comb begin
    remq = {rem, quo[WIDTH-1]};
    diff = remq - {1'b0, div};
    if (!diff[WIDTH]) begin
      rem_n = diff[WIDTH-1:0];
      quo_n = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_n = remq[WIDTH-1:0];
      quo_n = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider_multicycle.sv
// Iterative restoring divider for RV64M DIV/DIVU/REM/REMU with an en/done stall handshake.
module divider_multicycle
  import divider_multicycle_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             done
);

  localparam int unsigned CNT_W = div_cnt_w(WIDTH);

  div_state_t       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] div;
  u1                neg_q;
  u1                neg_r;

  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;
  u1                a_neg;
  u1                b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  // Magnitudes of the operands; INT_MIN stays 2^(W-1) as an unsigned value.
  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign a_abs = a_neg ? WIDTH'(-a) : a;
  assign b_abs = b_neg ? WIDTH'(-b) : b;

  assign done = ~en | (state == DIV_DONE);

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem   (rem),
    .quo   (quo),
    .div   (div),
    .rem_n (rem_n),
    .quo_n (quo_n)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DIV_IDLE;
      count <= '0;
      rem   <= '0;
      quo   <= '0;
      div   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      q     <= '0;
      r     <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (en && (b == '0)) begin
            q     <= '1;
            r     <= a;
            state <= DIV_DONE;
          end else if (en) begin
            rem   <= '0;
            quo   <= a_abs;
            div   <= b_abs;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            count <= CNT_W'(WIDTH);
            state <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          // Dropping en flushes the op; q/r keep the previous result.
          if (!en) begin
            state <= DIV_IDLE;
          end else begin
            rem   <= rem_n;
            quo   <= quo_n;
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
              q     <= neg_q ? WIDTH'(-quo_n) : quo_n;
              r     <= neg_r ? WIDTH'(-rem_n) : rem_n;
              state <= DIV_DONE;
            end
          end
        end
        DIV_DONE: state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_multicycle.sv
// Directed checks of the multicycle divider: results, latency, divide-by-zero, overflow, flush, reset.
module tb_divider_multicycle;

  localparam logic [63:0] M1   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] M2   = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [63:0] M3   = 64'hFFFF_FFFF_FFFF_FFFD;
  localparam logic [63:0] M5   = 64'hFFFF_FFFF_FFFF_FFFB;
  localparam logic [63:0] M7   = 64'hFFFF_FFFF_FFFF_FFF9;
  localparam logic [63:0] M100 = 64'hFFFF_FFFF_FFFF_FF9C;
  localparam logic [63:0] IMIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] IMAX = 64'h7FFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        is_signed;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] q;
  logic [63:0] r;
  logic        done;

  int total = 0;
  int bad   = 0;
  int n;
  logic [63:0] q_keep;
  logic [63:0] r_keep;

  always #5 clk = ~clk;

  divider_multicycle #(.WIDTH(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .q         (q),
    .r         (r),
    .done      (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts an op in the next cycle (cycle 0 of the op).
  task automatic start(input logic sgn, input logic [63:0] aa, input logic [63:0] bb);
    @(posedge clk); #1;
    en = 1'b1; is_signed = sgn; a = aa; b = bb;
  endtask

  // Counts cycles from the current one until done is seen; bounded.
  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (done) return;
      if (cyc >= 200) begin
        total++; bad++;
        $error("FAIL %s_timeout: got=no done expected=done within 200 cycles", tag);
        return;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic finish_op;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic op(input string tag, input logic sgn, input logic [63:0] aa, input logic [63:0] bb,
                    input logic [63:0] eq, input logic [63:0] er, input int ecyc);
    int c;
    start(sgn, aa, bb);
    wait_done(tag, c);
    check({tag, "_cyc"}, 64'(c), 64'(ecyc));
    check({tag, "_q"}, q, eq);
    check({tag, "_r"}, r, er);
    finish_op();
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_q", q, 64'd0);
    check("rst_r", r, 64'd0);
    check("rst_done", 64'(done), 64'd1);

    op("u_100_7",   1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65);
    op("s_m7_2",    1'b1, M7, 64'd2, M3, M1, 65);
    op("s_7_m2",    1'b1, 64'd7, M2, M3, 64'd1, 65);
    op("s_m100_m7", 1'b1, M100, M7, 64'd14, M2, 65);
    op("s_dz",      1'b1, 64'h1234, 64'd0, M1, 64'h1234, 1);
    op("u_dz",      1'b0, 64'h1234, 64'd0, M1, 64'h1234, 1);
    op("s_dz_neg",  1'b1, M5, 64'd0, M1, M5, 1);
    op("s_ovf",     1'b1, IMIN, M1, IMIN, 64'd0, 65);
    op("u_max_1",   1'b0, M1, 64'd1, M1, 64'd0, 65);
    op("u_max_2",   1'b0, M1, 64'd2, IMAX, 64'd1, 65);

    // Flush in cycle 30: previous result must survive.
    q_keep = q; r_keep = r;
    start(1'b0, 64'd1000, 64'd3);
    repeat (30) @(posedge clk);
    #1 en = 1'b0;
    @(negedge clk);
    check("flush_done", 64'(done), 64'd1);
    check("flush_q", q, q_keep);
    check("flush_r", r, r_keep);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("flush_q_late", q, q_keep);
    check("flush_r_late", r, r_keep);
    op("post_flush", 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65);

    // Reset in cycle 40 of an op.
    start(1'b1, M100, 64'd3);
    repeat (40) @(posedge clk);
    #1 reset = 1'b1; en = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_q", q, 64'd0);
    check("midrst_r", r, 64'd0);
    check("midrst_done", 64'(done), 64'd1);
    repeat (70) @(posedge clk);
    @(negedge clk);
    check("midrst_q_late", q, 64'd0);
    op("post_rst", 1'b1, M100, M7, 64'd14, M2, 65);

    // Back-to-back with en held: DONE -> IDLE -> BUSY adds one cycle beyond a fresh op.
    start(1'b0, 64'd100, 64'd7);
    wait_done("b2b_1", n);
    check("b2b_1_cyc", 64'(n), 64'd65);
    check("b2b_1_q", q, 64'd14);
    @(posedge clk); #1;
    a = 64'd200; b = 64'd7;
    wait_done("b2b_2", n);
    check("b2b_gap", 64'(n + 1), 64'd66);
    check("b2b_2_q", q, 64'd28);
    check("b2b_2_r", r, 64'd4);
    finish_op();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
